// File: rtl/stack_arbiter_if.sv
// Handshake bundle between the two stack clients, the arbiter and the operator stack.
// Ports: req_* / rsp_dat are per-client (index 0 = infix converter, 1 = RPN evaluator);
//        stk_* is the single stack port. master = clients + stack side, slave = arbiter.
interface stack_arbiter_if #(
  parameter int DW = 8
);
  // Client request side (bit/element n belongs to client n)
  logic [1:0]         req_stb;
  logic [1:0]         req_op;    // 1 = push, 0 = pop
  logic [1:0][DW-1:0] req_dat;
  logic [1:0]         req_lock;
  logic [1:0]         req_ack;
  logic [1:0]         req_err;
  logic [1:0][DW-1:0] rsp_dat;

  // Stack port
  logic               stk_stb;
  logic               stk_op;
  logic [DW-1:0]      stk_wdat;
  logic               stk_ack;
  logic [DW-1:0]      stk_rdat;

  modport master (
    output req_stb, req_op, req_dat, req_lock, stk_ack, stk_rdat,
    input  req_ack, req_err, rsp_dat, stk_stb, stk_op, stk_wdat
  );

  modport slave (
    input  req_stb, req_op, req_dat, req_lock, stk_ack, stk_rdat,
    output req_ack, req_err, rsp_dat, stk_stb, stk_op, stk_wdat
  );
endinterface

// File: rtl/stack_arbiter.sv
// Arbitrates two clients onto one operator stack, tracks occupancy, rejects over/underflow, supports lock.
// Latency: legal op = STK_ACK cycle + 1 (min 2 cycles); rejected op acks 1 cycle after STB.
// Backpressure: requests held until ACK; stack may stall via STK_ACK; losing client waits indefinitely.
// Ports: clk_i/rst_i (sync active-high), bus (slave modport of stack_arbiter_if),
//        count_o occupancy, full_o / empty_o derived from the registered count.
module stack_arbiter #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int CW    = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  stack_arbiter_if.slave bus,
  output logic [CW-1:0]  count_o,
  output logic           full_o,
  output logic           empty_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          op_q, op_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          own_vld_q, own_vld_d;
  logic          own_q, own_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [CW-1:0] count_q, count_d;

  logic          own_hold;
  logic          sel_vld;
  logic          sel;
  logic          illegal;

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Request selection. A locking owner shuts the other client out even while
  // the owner itself has nothing pending.
  always_comb begin
    own_hold = own_vld_q && bus.req_lock[own_q];
    sel_vld  = 1'b0;
    sel      = 1'b0;
    if (own_hold) begin
      sel_vld = bus.req_stb[own_q];
      sel     = own_q;
    end else if (bus.req_stb[0] && bus.req_stb[1]) begin
      sel_vld = 1'b1;
      sel     = ~last_q;
    end else if (bus.req_stb[0]) begin
      sel_vld = 1'b1;
      sel     = 1'b0;
    end else if (bus.req_stb[1]) begin
      sel_vld = 1'b1;
      sel     = 1'b1;
    end
  end

  assign illegal = (bus.req_op[sel] && full_o) || (!bus.req_op[sel] && empty_o);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    op_d      = op_q;
    err_d     = err_q;
    last_d    = last_q;
    own_vld_d = own_vld_q;
    own_d     = own_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        // Owner released its lock: ownership ends now so this cycle arbitrates normally.
        if (own_vld_q && !bus.req_lock[own_q]) begin
          own_vld_d = 1'b0;
        end
        if (sel_vld) begin
          grant_d = sel;
          op_d    = bus.req_op[sel];
          wdat_d  = bus.req_dat[sel];
          rdat_d  = '0;
          if (illegal) begin
            // Reject without touching the stack; count stays as is.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (bus.stk_ack) begin
          if (op_q) begin
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q - CW'(1);
            rdat_d  = bus.stk_rdat;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        last_d    = grant_q;
        own_vld_d = bus.req_lock[grant_q];
        own_d     = grant_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.req_ack  = '0;
    bus.req_err  = '0;
    bus.rsp_dat  = '0;
    bus.stk_stb  = 1'b0;
    bus.stk_op   = 1'b0;
    bus.stk_wdat = '0;
    if (state_q == RESP) begin
      bus.req_ack[grant_q] = 1'b1;
      bus.req_err[grant_q] = err_q;
      bus.rsp_dat[grant_q] = rdat_q;
    end
    if (state_q == ISSUE) begin
      bus.stk_stb  = 1'b1;
      bus.stk_op   = op_q;
      bus.stk_wdat = wdat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;  // client 0 wins the first tie
      own_vld_q <= 1'b0;
      own_q     <= 1'b0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      err_q     <= err_d;
      last_q    <= last_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed vector table, multi-cycle corner sequences, and
// randomized two-client traffic checked against a queue-based stack model.
// A behavioural stack with programmable ACK delay sits on the stack port.
module tb_stack_arbiter;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = 5;

  logic          clk;
  logic          rst;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  stack_arbiter_if #(.DW(DW)) bus ();

  stack_arbiter #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural stack on the stack port ----------------
  logic [DW-1:0] smem [0:31];
  int            sp;
  int            wait_cnt;
  int            stk_dly;
  bit            stk_hold;

  always_comb begin
    bus.stk_ack  = bus.stk_stb && !stk_hold && (wait_cnt >= stk_dly);
    bus.stk_rdat = (sp > 0) ? smem[sp-1] : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      sp       <= 0;
      wait_cnt <= 0;
    end else if (bus.stk_ack) begin
      if (bus.stk_op) begin
        smem[sp] <= bus.stk_wdat;
        sp       <= sp + 1;
      end else begin
        sp <= sp - 1;
      end
      wait_cnt <= 0;
    end else if (bus.stk_stb) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    bus.req_stb  = '0;
    bus.req_op   = '0;
    bus.req_dat  = '0;
    bus.req_lock = '0;
    stk_hold     = 1'b0;
    stk_dly      = 0;
    rst          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One request from one client; returns response and latency in cycles
  // (1 = ACK in the cycle after STB was seen). Leaves one idle cycle after.
  task automatic do_req(input int cl, input bit op, input logic [7:0] dat, input bit lock,
                        input int dly, output bit err, output logic [7:0] rd,
                        output int lat, output bit saw_stk);
    stk_dly = dly;
    saw_stk = 1'b0;
    lat     = -1;
    err     = 1'b0;
    rd      = '0;
    bus.req_stb[cl]  = 1'b1;
    bus.req_op[cl]   = op;
    bus.req_dat[cl]  = dat;
    bus.req_lock[cl] = lock;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.stk_stb) saw_stk = 1'b1;
      if (bus.req_ack[cl]) begin
        err = bus.req_err[cl];
        rd  = bus.rsp_dat[cl];
        lat = k;
        break;
      end
    end
    bus.req_stb[cl] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          cl;
    bit          op;
    logic [7:0]  dat;
    int          dly;
    bit          exp_err;
    logic [7:0]  exp_dat;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  bit          e;
  logic [7:0]  r;
  int          lat;
  bit          ss;
  int          t0, t1;
  logic [7:0]  r0, r1;
  bit          any_ack;
  logic [7:0]  mq [$];

  initial begin
    // {client, op, data, stack delay, err, rsp data, count after, latency}
    vecs[0] = '{0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 0, 1};
    vecs[1] = '{0, 1'b1, 8'h2B, 2, 1'b0, 8'h00, 1, 4};
    vecs[2] = '{0, 1'b1, 8'h2A, 2, 1'b0, 8'h00, 2, 4};
    vecs[3] = '{1, 1'b0, 8'h00, 2, 1'b0, 8'h2A, 1, 4};
    vecs[4] = '{1, 1'b0, 8'h00, 0, 1'b0, 8'h2B, 0, 2};
    vecs[5] = '{1, 1'b1, 8'h41, 1, 1'b0, 8'h00, 1, 3};
    vecs[6] = '{0, 1'b0, 8'h00, 1, 1'b0, 8'h41, 0, 3};

    do_reset();

    // ---- reset values ----
    chk("rst_ack",   32'(bus.req_ack), 32'h0);
    chk("rst_err",   32'(bus.req_err), 32'h0);
    chk("rst_rsp",   32'(bus.rsp_dat), 32'h0);
    chk("rst_stb",   32'(bus.stk_stb), 32'h0);
    chk("rst_op",    32'(bus.stk_op), 32'h0);
    chk("rst_wdat",  32'(bus.stk_wdat), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full",  32'(full), 32'h0);

    // ---- vector table ----
    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].cl, vecs[i].op, vecs[i].dat, 1'b0, vecs[i].dly, e, r, lat, ss);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_dat", i), 32'(r), 32'(vecs[i].exp_dat));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_stk", i), 32'(ss), 32'(!vecs[i].exp_err));
    end

    // ---- round-robin tie, twice ----
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      t0 = -1; t1 = -1;
      bus.req_op   = 2'b11;
      bus.req_dat[0] = 8'h30;
      bus.req_dat[1] = 8'h31;
      bus.req_stb  = 2'b11;
      for (int k = 1; k <= 50 && (t0 < 0 || t1 < 0); k++) begin
        @(negedge clk);
        if (bus.req_ack[0] && t0 < 0) begin t0 = k; bus.req_stb[0] = 1'b0; end
        if (bus.req_ack[1] && t1 < 0) begin t1 = k; bus.req_stb[1] = 1'b0; end
      end
      bus.req_stb = 2'b00;
      @(negedge clk);
      chk($sformatf("rr%0d_t0", rep), 32'(t0), 32'd2);
      chk($sformatf("rr%0d_t1", rep), 32'(t1), 32'd5);
    end
    chk("rr_count", 32'(count), 32'd4);
    do_req(0, 1'b0, 8'h00, 1'b0, 0, e, r, lat, ss);
    chk("rr_pop1", 32'(r), 32'h31);
    do_req(0, 1'b0, 8'h00, 1'b0, 0, e, r, lat, ss);
    chk("rr_pop2", 32'(r), 32'h30);

    // ---- full boundary ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1, 1'b1, 8'h50 + 8'(i), 1'b0, 0, e, r, lat, ss);
      chk($sformatf("fill%0d_err", i), 32'(e), 32'h0);
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_flag",  32'(full), 32'h1);
    do_req(1, 1'b1, 8'h99, 1'b0, 0, e, r, lat, ss);
    chk("ovf_err",   32'(e), 32'h1);
    chk("ovf_stk",   32'(ss), 32'h0);
    chk("ovf_lat",   32'(lat), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    do_req(1, 1'b0, 8'h00, 1'b0, 0, e, r, lat, ss);
    chk("full_pop_dat", 32'(r), 32'h5F);
    chk("full_pop_flag", 32'(full), 32'h0);
    chk("full_pop_cnt", 32'(count), 32'd15);

    // ---- lock: client 0 pops three under lock while client 1 waits ----
    do_reset();
    do_req(0, 1'b1, 8'h2F, 1'b0, 0, e, r, lat, ss);
    do_req(0, 1'b1, 8'h2A, 1'b0, 0, e, r, lat, ss);
    do_req(0, 1'b1, 8'h2D, 1'b0, 0, e, r, lat, ss);
    any_ack = 1'b0;
    bus.req_op[0] = 1'b0; bus.req_lock[0] = 1'b1; bus.req_stb[0] = 1'b1;
    @(negedge clk);
    bus.req_op[1] = 1'b1; bus.req_dat[1] = 8'h33; bus.req_stb[1] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      r = 8'hFF;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (bus.req_ack[1]) any_ack = 1'b1;
        if (bus.req_ack[0]) begin r = bus.rsp_dat[0]; break; end
      end
      bus.req_stb[0] = 1'b0;
      chk($sformatf("lock_pop%0d", p), 32'(r), (p == 0) ? 32'h2D : (p == 1) ? 32'h2A : 32'h2F);
      @(negedge clk);
      if (bus.req_ack[1]) any_ack = 1'b1;
      if (p < 2) bus.req_stb[0] = 1'b1;
    end
    // Owner idles with lock held: client 1 must still be shut out.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.req_ack[1]) any_ack = 1'b1;
    end
    chk("lock_excl", 32'(any_ack), 32'h0);
    bus.req_lock[0] = 1'b0;
    t1 = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.req_ack[1]) begin t1 = k; break; end
    end
    bus.req_stb[1] = 1'b0;
    @(negedge clk);
    chk("lock_release_lat", 32'(t1), 32'd2);
    chk("lock_count", 32'(count), 32'd1);

    // ---- reset during ISSUE with STK_ACK withheld ----
    do_reset();
    do_req(0, 1'b1, 8'h11, 1'b0, 0, e, r, lat, ss);
    stk_hold = 1'b1;
    bus.req_op[0] = 1'b1; bus.req_dat[0] = 8'h22; bus.req_stb[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_issue_stb", 32'(bus.stk_stb), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb",   32'(bus.stk_stb), 32'h0);
    chk("mid_rst_count", 32'(count), 32'h0);
    rst = 1'b0;
    bus.req_stb = 2'b00;
    stk_hold = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.req_ack != 2'b00) any_ack = 1'b1;
    end
    chk("mid_rst_noack", 32'(any_ack), 32'h0);

    // ---- randomized two-client traffic vs queue model ----
    do_reset();
    mq.delete();
    begin
      bit pend [2];
      bit rop  [2];
      int age  [2];
      int push_pct;
      bit x_err;
      logic [7:0] x_dat;
      pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        if (!bus.stk_stb) stk_dly = int'($urandom_range(0, 3));
        push_pct = ((cyc / 300) % 2 == 0) ? 75 : 25;
        for (int i = 0; i < 2; i++) begin
          if (bus.req_ack[i]) begin
            if (!pend[i]) begin
              chk($sformatf("rnd_spurious_ack%0d", i), 32'h1, 32'h0);
            end else begin
              if (rop[i]) begin
                x_err = (mq.size() == DEPTH);
                x_dat = 8'h00;
                if (!x_err) mq.push_back(bus.req_dat[i]);
              end else begin
                x_err = (mq.size() == 0);
                x_dat = x_err ? 8'h00 : mq.pop_back();
              end
              chk($sformatf("rnd_err%0d", i), 32'(bus.req_err[i]), 32'(x_err));
              chk($sformatf("rnd_dat%0d", i), 32'(bus.rsp_dat[i]), 32'(x_dat));
              chk("rnd_count", 32'(count), 32'(mq.size()));
              chk("rnd_flags", {30'd0, full, empty},
                  {30'd0, mq.size() == DEPTH, mq.size() == 0});
            end
            pend[i] = 0;
            bus.req_stb[i] = 1'b0;
          end else if (pend[i]) begin
            age[i]++;
            if (age[i] > 200) begin
              chk($sformatf("rnd_timeout%0d", i), 32'(age[i]), 32'd200);
              pend[i] = 0;
              bus.req_stb[i] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            rop[i]  = ($urandom_range(0, 99) < push_pct);
            pend[i] = 1;
            age[i]  = 0;
            bus.req_op[i]  = rop[i];
            bus.req_dat[i] = 8'($urandom);
            bus.req_stb[i] = 1'b1;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares the single operator stack of the RPN calculator between two requesters: client 0 (the infix-to-RPN converter) and client 1 (the RPN evaluator/output stage). It serialises push and pop requests through one stack port and tracks stack occupancy. It rejects overflow and underflow with an error response instead of touching the stack. A client can lock the stack for an atomic multi-op sequence, such as flushing every operator on `=`.

## Interface
Parameters:
- `DEPTH`, 16: stack capacity in entries.
- `DW`, 8: data width; ASCII characters.
- `CW`, 5: width of `COUNT`; must be at least clog2(`DEPTH`+1).

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset, synchronous, active-high.
- `REQn_STB`, in, 1 (n = 0, 1): request valid. Held with its payload until `REQn_ACK` is seen.
- `REQn_OP`, in, 1: 1 = push, 0 = pop.
- `REQn_DAT`, in, `DW`: push data.
- `REQn_LOCK`, in, 1: keep ownership after the current request.
- `REQn_ACK`, out, 1: one-cycle completion pulse.
- `REQn_ERR`, out, 1: valid with `ACK`; 1 = rejected (push when full, pop when empty).
- `RSPn_DAT`, out, `DW`: popped data, valid with `ACK`. It is 0 on push or error.
- `STK_STB`, out, 1: stack operation request.
- `STK_OP`, out, 1: 1 = push, 0 = pop.
- `STK_WDAT`, out, `DW`: push data to the stack.
- `STK_ACK`, in, 1: stack completed the operation. May arrive in the same cycle as `STK_STB`.
- `STK_RDAT`, in, `DW`: pop data, valid with `STK_ACK`.
- `COUNT`, out, `CW`: current occupancy.
- `FULL`, out, 1: `COUNT` == `DEPTH`.
- `EMPTY`, out, 1: `COUNT` == 0.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE, request selection:**
  - If an owner is recorded and its `REQ_LOCK` is still high, only the owner is eligible.
  - Otherwise, if both clients request, round-robin picks the client not granted last.
  - Otherwise the single requester wins.
  - Grant, op and data are registered on the transition.
- **IDLE, legality check:**
  - Push with `FULL` or pop with `EMPTY` goes IDLE→RESP with `ERR`=1 and `RSP_DAT`=0. The stack is not accessed and `COUNT` is unchanged.
  - Any other request goes IDLE→ISSUE.
- **ISSUE:** `STK_STB`=1 with `STK_OP`/`STK_WDAT` from the registered request, held until `STK_ACK`. On `STK_ACK`:
  - `COUNT` is incremented on a push and decremented on a pop.
  - For a pop, `STK_RDAT` is captured into `RSPn_DAT`.
  - The FSM moves to RESP.
- **RESP:**
  - The granted `REQn_ACK`=1 for exactly one cycle, with `ERR` and `RSP_DAT` valid.
  - `last_grant` is updated.
  - Owner becomes the granted client if its `REQ_LOCK`=1; otherwise it is cleared.
  - The FSM returns to IDLE.
- **Lock behaviour:**
  - The owner keeps exclusivity while `LOCK` is high, even with no `STB` pending. The other client waits indefinitely; no timeout.
  - If the owner drops `LOCK` while in IDLE, ownership clears in that cycle and arbitration is normal.
- **Handshake rules:**
  - Requesters deassert `STB` on the edge at which they sample `ACK`=1. A new request may be raised in the following cycle.
  - `STB` is ignored during ISSUE/RESP for the non-granted client. That request stays pending and is not dropped.
- **Derived outputs:** `FULL`/`EMPTY` are derived from the registered `COUNT`. A push and a pop cannot overlap, so `COUNT` never over- or underflows.

## Timing
- **Reset values:**
  - All `ACK`, `ERR`, `RSP_DAT`, `STK_STB`, `STK_OP` and `STK_WDAT` are 0.
  - `COUNT`=0, `EMPTY`=1, `FULL`=0.
  - State is IDLE, owner is none, and `last_grant`=1 so client 0 wins the first tie.
- **Legal-op latency:** `STB` is seen in IDLE at cycle 0 and `STK_STB` rises at cycle 1. If `STK_ACK` arrives at cycle k≥1, `ACK` is at cycle k+1. The minimum is 2 cycles; throughput is one op per 3 cycles minimum.
- **Error latency:** `STB` at cycle 0 gives `ACK`+`ERR` at cycle 1.
- **`COUNT` update:** `COUNT` updates at the edge ending the `STK_ACK` cycle, so new `FULL`/`EMPTY` are visible in RESP.
- **Reset mid-operation:** `RST` in any state returns everything to reset values in the next cycle. `STK_STB` drops and no `ACK` is issued. The stack shares `RST`, so `COUNT`=0 stays consistent with it.

## Test plan
- **Empty pop after reset:** reset, then client 0 pops → `ACK0`=1, `ERR0`=1, `RSP0_DAT`=0x00 one cycle after `STB`. `STK_STB` never rises and `COUNT`=0.
- **Basic push/pop with delayed stack:** client 0 pushes 0x2B then 0x2A (stack acks after 2 cycles); client 1 pops → `RSP1_DAT`=0x2A, `ERR1`=0, `COUNT`=1, `ACK1` 3 cycles after `STK_STB` rise.
- **Round-robin tie:** after reset, both push together (0x30 on client 0, 0x31 on client 1) → client 0 served first, then client 1. Repeating the tie serves client 0 first again. Two pops return 0x31, then 0x30.
- **Full boundary:** 16 pushes from client 1 → `COUNT`=16, `FULL`=1. A 17th push → `ERR1`=1 and no `STK_STB`. One pop → `FULL`=0, `COUNT`=15.
- **Lock:** client 0 holds `LOCK` and pops 3 entries (0x2D, 0x2A, 0x2F pushed earlier) while client 1 holds a pending push of 0x33. Client 1 gets no `ACK` until client 0 drops `LOCK`, then its push is acked 2 cycles later.
- **Reset mid-operation:** assert `RST` during ISSUE with `STK_ACK` withheld → next cycle `STK_STB`=0 and `COUNT`=0, and no `ACK` is ever issued for that request.
